// File: rtl/msg_receive.sv
// Serial message receiver: start / MSG_W data bits LSB first / stop, mid-bit sampled.
// Define MSG_RECEIVE_PARITY_EN to add an even-parity bit and the parityErr output.
//
// state  | meaning
// IDLE   | line idle, waiting for synchronized low
// START  | confirming start bit at its midpoint
// DATA   | sampling MSG_W payload bits, one per BIT_TICKS
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling stop bit, registering valid / error result
module msg_receive #(
  parameter int BIT_TICKS = 16,
  parameter int MSG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  output logic [MSG_W-1:0] msg,
  output logic             valid,
  output logic             frameErr,
`ifdef MSG_RECEIVE_PARITY_EN
  output logic             parityErr,
`endif
  output logic             busy
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int IW = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CW-1:0] HALF_M1   = CW'(BIT_TICKS / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(MSG_W - 1);

`ifdef MSG_RECEIVE_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_n;
  logic             sync1, ser_s;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [MSG_W-1:0] shift;
  logic             cnt_clr, take_bit, done_ok, done_ferr;
`ifdef MSG_RECEIVE_PARITY_EN
  logic             par_bit, take_par, done_perr;
`endif

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      ser_s <= 1'b1;
    end else begin
      sync1 <= serIn;
      ser_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    take_bit  = 1'b0;
    done_ok   = 1'b0;
    done_ferr = 1'b0;
`ifdef MSG_RECEIVE_PARITY_EN
    take_par  = 1'b0;
    done_perr = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!ser_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr = 1'b1;
          state_n = ser_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST_TICK) begin
          cnt_clr  = 1'b1;
          take_bit = 1'b1;
`ifdef MSG_RECEIVE_PARITY_EN
          if (bit_idx == LAST_BIT) state_n = PARITY;
`else
          if (bit_idx == LAST_BIT) state_n = STOP;
`endif
        end
      end
`ifdef MSG_RECEIVE_PARITY_EN
      PARITY: begin
        if (cnt == LAST_TICK) begin
          cnt_clr  = 1'b1;
          take_par = 1'b1;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST_TICK) begin
          cnt_clr = 1'b1;
          state_n = IDLE;
          // A bad stop bit outranks a parity error.
          if (!ser_s)                        done_ferr = 1'b1;
`ifdef MSG_RECEIVE_PARITY_EN
          else if (^{shift, par_bit})        done_perr = 1'b1;
`endif
          else                               done_ok   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      msg      <= '0;
      valid    <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      valid    <= done_ok;
      frameErr <= done_ferr;
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + CW'(1);
      if (state != DATA) bit_idx <= '0;
      else if (take_bit) bit_idx <= bit_idx + IW'(1);
      if (take_bit) shift[bit_idx] <= ser_s;
      if (done_ok)  msg <= shift;
    end
  end

`ifdef MSG_RECEIVE_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit   <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      parityErr <= done_perr;
      if (take_par) par_bit <= ser_s;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule
